axi_4_lite_arb: RTL
===================

Name: axi_4_lite_arb

Overview:
- Two-requester arbiter and sequencer driving one AXI4-Lite master port into the team's AXI4-Lite slave register file.
- Each requester issues single-word read or write commands on a simple valid/ready interface.
- The block grants one requester at a time, runs the full AXI4-Lite transaction, then returns data and response to that requester.
- Sits between the processing-side clients and the AXI4-Lite slave.

Parameters:
- ADDR_WIDTH, 32, AXI address width; matches `C_AXI_ADDR_WIDTH.
- DATA_WIDTH, 32, AXI data width; matches `C_AXI_DATA_WIDTH.
- STRB_WIDTH, DATA_WIDTH/8, write strobe width.

Ports:
- M_AXI_ACLK  in  1  the single clock for the block.
- M_AXI_ARESET  in  1  reset; synchronous, active-high.
- REQ_VALID  in  2  per-requester command valid; bit i belongs to requester i.
- REQ_READY  out  2  per-requester command accept; at most one bit set.
- REQ_WE  in  2  1 = write, 0 = read.
- REQ_ADDR  in  2*ADDR_WIDTH  packed addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- REQ_WDATA  in  2*DATA_WIDTH  packed write data.
- REQ_WSTRB  in  2*STRB_WIDTH  packed write strobes.
- RSP_VALID  out  2  one-cycle completion pulse, one-hot.
- RSP_RDATA  out  DATA_WIDTH  read data; valid with RSP_VALID; 0 for writes.
- RSP_RESP  out  2  BRESP or RRESP of the completed transaction.
- M_AXI_AWVALID/AWREADY/AWADDR/AWPROT  out/in/out/out  1/1/ADDR_WIDTH/3  write address channel.
- M_AXI_WVALID/WREADY/WDATA/WSTRB  out/in/out/out  1/1/DATA_WIDTH/STRB_WIDTH  write data channel.
- M_AXI_BVALID/BREADY/BRESP  in/out/in  1/1/2  write response channel.
- M_AXI_ARVALID/ARREADY/ARADDR/ARPROT  out/in/out/out  1/1/ADDR_WIDTH/3  read address channel.
- M_AXI_RVALID/RREADY/RDATA/RRESP  in/out/in/in  1/1/DATA_WIDTH/2  read data channel.

Behaviour:
- Reset (M_AXI_ARESET high at a clock edge):
  - State = IDLE.
  - All VALID/READY outputs = 0, including REQ_READY, RSP_VALID, AW/W/AR VALID, BREADY, RREADY.
  - Address/data/strobe outputs = 0; RSP_RESP = 2'b00.
  - Round-robin pointer last_grant = 1, so requester 0 wins the first contention.
- Reset mid-transaction: outstanding AXI transaction and pending response are discarded; no RSP_VALID is emitted.
- AWPROT and ARPROT are constant 3'b000.
- States: IDLE, WR_AW_W, WR_B, RD_AR, RD_R, RESP.
- Arbitration (IDLE only):
  - Grant = requester with REQ_VALID set; if both are set, grant the one not equal to last_grant.
  - REQ_READY[grant] is combinational and asserted only in IDLE.
  - On that edge: latch WE/ADDR/WDATA/WSTRB, set last_grant = grant.
  - Go to WR_AW_W if WE=1, else RD_AR.
- WR_AW_W:
  - AWVALID and WVALID assert together on entry (registered).
  - Each drops independently after its own handshake (VALID & READY); either order, or both in the same cycle.
  - VALID never drops before its handshake; address and data stay stable.
  - When both handshakes are done, go to WR_B.
- WR_B: BREADY = 1; on BVALID, capture BRESP and go to RESP.
- RD_AR: ARVALID = 1 until ARREADY; then go to RD_R.
- RD_R: RREADY = 1; on RVALID, capture RDATA and RRESP and go to RESP.
- RESP:
  - One cycle: RSP_VALID[grant] = 1 with RSP_RDATA and RSP_RESP.
  - RSP_RDATA = 0 for writes.
  - Next state IDLE.
- Latency (zero-wait slave):
  - Request accepted at edge T.
  - AW/W (or AR) valid in cycle T+1.
  - B/R handshake in T+2.
  - RSP_VALID in T+3.
  - Next grant possible in T+4.
- Only one outstanding transaction at a time; no read/write overlap.
- REQ_VALID changes outside IDLE have no effect.
- Responses SLVERR and DECERR are passed through unchanged; the arbiter does not retry.
- Fairness: a continuously asserted requester waits at most one transaction of the other requester.

Optional Feature:
- Macro: AXI_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; requester 0 always wins contention; last_grant is still updated but ignored.
- Undefined (default): round-robin as specified above.

Test Plan:
- Single write, requester 0: addr 0x4, data 0xDEADBEEF, strb 0xF, slave always ready → AW/W in T+1, RSP_VALID=2'b01 at T+3, RSP_RESP=2'b00; a read of 0x4 returns 0xDEADBEEF.
- Single read, requester 1: addr 0x8 after reset → ARADDR=0x8, RSP_VALID=2'b10, RSP_RDATA=0x00000000.
- Contention: both REQ_VALID held high for 4 transactions → grants 0,1,0,1.
  - With AXI_ARB_FIXED_PRIO_EN defined: grants 0,0,0,0.
- Split handshake: slave holds WREADY=0 for 3 cycles while AWREADY=1 → AWVALID drops after 1 cycle; WVALID stays high with data stable until WREADY; exactly one RSP_VALID.
- Error pass-through: slave returns BRESP=2'b10 → RSP_RESP=2'b10 on requester 0; FSM returns to IDLE.
- Reset mid-read: assert M_AXI_ARESET in RD_R → next cycle all outputs 0, no RSP_VALID; next contended grant goes to requester 0.

Source files
------------

// File: rtl/axi_4_lite_arb.sv
`default_nettype none
// ============================================================================
// Module : axi_4_lite_arb
// Brief  : Two-requester arbiter sequencing single-word commands onto one
//          AXI4-Lite master port. Define AXI_ARB_FIXED_PRIO_EN for fixed
//          priority (requester 0 wins); default is round-robin.
// Rev    : 1.0 - initial release
// ============================================================================
module axi_4_lite_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    M_AXI_ACLK,
  input  logic                    M_AXI_ARESET,
  input  logic [1:0]              REQ_VALID,
  output logic [1:0]              REQ_READY,
  input  logic [1:0]              REQ_WE,
  input  logic [2*ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [2*DATA_WIDTH-1:0] REQ_WDATA,
  input  logic [2*STRB_WIDTH-1:0] REQ_WSTRB,
  output logic [1:0]              RSP_VALID,
  output logic [DATA_WIDTH-1:0]   RSP_RDATA,
  output logic [1:0]              RSP_RESP,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [STRB_WIDTH-1:0]   M_AXI_WSTRB,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  input  logic [1:0]              M_AXI_BRESP,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,
  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY,
  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RESP    = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_grant;
  logic                  r_last_grant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_arvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_resp;

  logic                  w_grant;
  logic                  w_accept;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [STRB_WIDTH-1:0] w_wstrb;

  always_comb begin
`ifdef AXI_ARB_FIXED_PRIO_EN
    w_grant = ~REQ_VALID[0];
`else
    // Under contention the requester that did not win last time goes next.
    if (&REQ_VALID)
      w_grant = ~r_last_grant;
    else
      w_grant = REQ_VALID[1] & ~REQ_VALID[0];
`endif
  end

  assign w_accept = (r_state == IDLE) && (|REQ_VALID) && !M_AXI_ARESET;
  assign w_we     = w_grant ? REQ_WE[1] : REQ_WE[0];
  assign w_addr   = w_grant ? REQ_ADDR[2*ADDR_WIDTH-1:ADDR_WIDTH]   : REQ_ADDR[ADDR_WIDTH-1:0];
  assign w_wdata  = w_grant ? REQ_WDATA[2*DATA_WIDTH-1:DATA_WIDTH]  : REQ_WDATA[DATA_WIDTH-1:0];
  assign w_wstrb  = w_grant ? REQ_WSTRB[2*STRB_WIDTH-1:STRB_WIDTH]  : REQ_WSTRB[STRB_WIDTH-1:0];

  assign REQ_READY = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = w_we ? WR_AW_W : RD_AR;
      // A channel whose VALID is already low has completed its handshake.
      WR_AW_W: if ((!r_awvalid || M_AXI_AWREADY) && (!r_wvalid || M_AXI_WREADY))
                 w_next = WR_B;
      WR_B:    if (M_AXI_BVALID) w_next = RESP;
      RD_AR:   if (M_AXI_ARREADY) w_next = RD_R;
      RD_R:    if (M_AXI_RVALID) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_arvalid    <= 1'b0;
      r_rdata      <= '0;
      r_resp       <= 2'b00;
    end else begin
      if (w_accept) begin
        r_grant      <= w_grant;
        r_last_grant <= w_grant;
        r_addr       <= w_addr;
        r_wdata      <= w_wdata;
        r_wstrb      <= w_wstrb;
        r_awvalid    <= w_we;
        r_wvalid     <= w_we;
        r_arvalid    <= ~w_we;
        r_rdata      <= '0;
      end
      if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
      if (r_wvalid && M_AXI_WREADY)   r_wvalid  <= 1'b0;
      if (r_arvalid && M_AXI_ARREADY) r_arvalid <= 1'b0;
      if ((r_state == WR_B) && M_AXI_BVALID)
        r_resp <= M_AXI_BRESP;
      if ((r_state == RD_R) && M_AXI_RVALID) begin
        r_rdata <= M_AXI_RDATA;
        r_resp  <= M_AXI_RRESP;
      end
    end
  end

  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_BREADY  = (r_state == WR_B);
  assign M_AXI_ARVALID = r_arvalid;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_RREADY  = (r_state == RD_R);

  assign RSP_VALID = (r_state == RESP) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
  assign RSP_RDATA = r_rdata;
  assign RSP_RESP  = r_resp;

endmodule
`default_nettype wire
